// File: rtl/dmem_responder.sv
// Memory-stage responder: drives a word-wide data RAM over req/ack, stalls the pipeline and returns extended load data.
// Optional macro DMEM_TIMEOUT_EN aborts an unacknowledged request after TIMEOUT cycles and pulses bus_err_o.
module dmem_responder #(
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead_i,
    input  logic        memWrite_i,
    input  logic [1:0]  store_type_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] dataAddr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic        rvld_q, rvld_d;
    logic [1:0]  sz_q, sz_d, off_q, off_d;
    logic        uns_q, uns_d, load_q, load_d;
    logic        req_valid, aligned;
    logic [1:0]  sz_in;

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    function automatic logic [3:0] calc_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: calc_be = 4'b1000 >> off;
            SZ_HALF: calc_be = off[1] ? 4'b0011 : 4'b1100;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE: calc_wdata = {4{wd[7:0]}};
            SZ_HALF: calc_wdata = {2{wd[15:0]}};
            default: calc_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = word[31:24];
            2'b01:   b = word[23:16];
            2'b10:   b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (sz)
            SZ_BYTE: load_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_ext = word;
        endcase
    endfunction

    assign req_valid = memRead_i | memWrite_i;
    assign sz_in     = (store_type_i == 2'b11) ? SZ_WORD : store_type_i;
    assign aligned   = (sz_in == SZ_BYTE) ||
                       ((sz_in == SZ_HALF) && !dataAddr_i[0]) ||
                       ((sz_in == SZ_WORD) && (dataAddr_i[1:0] == 2'b00));

    assign misalign_o = (state_q == IDLE) && req_valid && !aligned;
    assign stall_o    = (state_q == REQ) || ((state_q == IDLE) && req_valid && aligned);

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvld_q;
    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_be_o      = be_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             berr_q, berr_d;
    assign bus_err_o = berr_q;
`else
    assign bus_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rvld_d  = 1'b0;
        sz_d    = sz_q;
        off_d   = off_q;
        uns_d   = uns_q;
        load_d  = load_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        berr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && aligned) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = memWrite_i;
                    be_d    = calc_be(sz_in, dataAddr_i[1:0]);
                    addr_d  = dataAddr_i[31:2];
                    wdata_d = calc_wdata(sz_in, wdata_i);
                    sz_d    = sz_in;
                    off_d   = dataAddr_i[1:0];
                    uns_d   = load_unsigned_i;
                    load_d  = ~memWrite_i;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (load_q) begin
                        rdata_d = load_ext(mem_rdata_i, sz_q, off_q, uns_q);
                        rvld_d  = 1'b1;
                    end
                end
`ifdef DMEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    if (load_q) begin
                        rdata_d = RESET_RDATA;
                        rvld_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= RESET_RDATA;
            rvld_q  <= 1'b0;
            sz_q    <= SZ_WORD;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            load_q  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= '0;
            berr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
            sz_q    <= sz_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            load_q  <= load_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            berr_q  <= berr_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table of single accesses, load-data scoreboard, reset and timeout sequences.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam logic [31:0] RST_RD = 32'h5A5A_0001;
`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead_i, memWrite_i, load_unsigned_i, mem_ack_i;
    logic [1:0]  store_type_i;
    logic [31:0] dataAddr_i, wdata_i, mem_rdata_i;
    logic        stall_o, rdata_valid_o, misalign_o, bus_err_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [29:0] mem_addr_o;

    dmem_responder #(.TIMEOUT(TO), .RESET_RDATA(RST_RD)) dut (
        .clk(clk), .rst_n(rst_n),
        .memRead_i(memRead_i), .memWrite_i(memWrite_i), .store_type_i(store_type_i),
        .load_unsigned_i(load_unsigned_i), .dataAddr_i(dataAddr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  st;
        logic        uns;
        logic [31:0] addr, wdata, ram;
        int          dly;
        logic        mis, we;
        logic [3:0]  be;
        logic [31:0] mwd, rdat;
    } vec_t;

    vec_t        vt[13];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Load data is scored whenever the DUT flags it valid.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rdata_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_valid_unexpected actual=1 required=0");
            end else begin
                chk("rdata_sb", rdata_o, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'h0, mem_req_o}, 32'h0);
        chk({tag, "_we"},    {31'h0, mem_we_o}, 32'h0);
        chk({tag, "_be"},    {28'h0, mem_be_o}, 32'h0);
        chk({tag, "_addr"},  {2'b00, mem_addr_o}, 32'h0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'h0);
        chk({tag, "_rdata"}, rdata_o, RST_RD);
        chk({tag, "_rvld"},  {31'h0, rdata_valid_o}, 32'h0);
        chk({tag, "_berr"},  {31'h0, bus_err_o}, 32'h0);
        chk({tag, "_stall"}, {31'h0, stall_o}, 32'h0);
    endtask

    task automatic clear_inputs();
        memRead_i = 1'b0; memWrite_i = 1'b0; store_type_i = 2'b00;
        load_unsigned_i = 1'b0; dataAddr_i = 32'h0; wdata_i = 32'h0;
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        memRead_i = v.rd; memWrite_i = v.wr; store_type_i = v.st;
        load_unsigned_i = v.uns; dataAddr_i = v.addr; wdata_i = v.wdata;
        #1;
        if (v.mis) begin
            chk("mis_flag",  {31'h0, misalign_o}, 32'h1);
            chk("mis_stall", {31'h0, stall_o}, 32'h0);
            chk("mis_req",   {31'h0, mem_req_o}, 32'h0);
            @(posedge clk); #1;
            chk("mis_req_after", {31'h0, mem_req_o}, 32'h0);
            chk("mis_flag_after", {31'h0, misalign_o}, 32'h1);
            clear_inputs();
            return;
        end
        chk("idle_misalign", {31'h0, misalign_o}, 32'h0);
        chk("idle_stall", {31'h0, stall_o}, 32'h1);
        @(posedge clk); #1;
        chk("req_req",   {31'h0, mem_req_o}, 32'h1);
        chk("req_stall", {31'h0, stall_o}, 32'h1);
        chk("req_we",    {31'h0, mem_we_o}, {31'h0, v.we});
        chk("req_be",    {28'h0, mem_be_o}, {28'h0, v.be});
        chk("req_addr",  {2'b00, mem_addr_o}, v.addr >> 2);
        if (v.we) chk("req_wdata", mem_wdata_o, v.mwd);
        for (int i = 0; i < v.dly; i++) begin
            @(posedge clk); #1;
            chk("wait_req", {31'h0, mem_req_o}, 32'h1);
            chk("wait_stall", {31'h0, stall_o}, 32'h1);
        end
        mem_ack_i = 1'b1;
        mem_rdata_i = v.ram;
        if (!v.we) exp_q.push_back(v.rdat);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        mem_rdata_i = $urandom;
        clear_inputs();
        #1;
        if (!v.we) last_rd = v.rdat;
        chk("done_stall", {31'h0, stall_o}, 32'h0);
        chk("done_req",   {31'h0, mem_req_o}, 32'h0);
        chk("done_berr",  {31'h0, bus_err_o}, 32'h0);
        chk("done_rdata", rdata_o, last_rd);
        @(posedge clk); #1;
        chk("idle_rdata_hold", rdata_o, last_rd);
    endtask

    initial begin
        //        rd wr st    uns addr          wdata         ram           dly mis we be       mwd           rdat
        vt[0]  = '{1, 0, 2'b00, 0, 32'h0000_0100, 32'h0,        32'h1234_5678, 0, 0, 0, 4'b1111, 32'h0,        32'h1234_5678};
        vt[1]  = '{1, 0, 2'b10, 0, 32'h0000_0103, 32'h0,        32'h0000_00F0, 0, 0, 0, 4'b0001, 32'h0,        32'hFFFF_FFF0};
        vt[2]  = '{1, 0, 2'b10, 1, 32'h0000_0103, 32'h0,        32'h0000_00F0, 1, 0, 0, 4'b0001, 32'h0,        32'h0000_00F0};
        vt[3]  = '{0, 1, 2'b01, 0, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0,        0, 0, 1, 4'b0011, 32'hBEEF_BEEF, 32'h0};
        vt[4]  = '{1, 0, 2'b00, 0, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0};
        vt[5]  = '{1, 0, 2'b10, 0, 32'h0000_0100, 32'h0,        32'h8012_3456, 2, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vt[6]  = '{1, 0, 2'b01, 0, 32'h0000_0102, 32'h0,        32'h1234_8001, 0, 0, 0, 4'b0011, 32'h0,        32'hFFFF_8001};
        vt[7]  = '{1, 0, 2'b01, 1, 32'h0000_0100, 32'h0,        32'hF00D_1234, 3, 0, 0, 4'b1100, 32'h0,        32'h0000_F00D};
        vt[8]  = '{0, 1, 2'b10, 0, 32'h0000_0301, 32'h1234_56A5, 32'h0,        1, 0, 1, 4'b0100, 32'hA5A5_A5A5, 32'h0};
        vt[9]  = '{0, 1, 2'b11, 0, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0,        0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vt[10] = '{1, 1, 2'b00, 0, 32'h0000_0008, 32'h0102_0304, 32'hFFFF_FFFF, 0, 0, 1, 4'b1111, 32'h0102_0304, 32'h0};
        vt[11] = '{1, 0, 2'b01, 0, 32'h0000_0203, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0};
        vt[12] = '{1, 0, 2'b10, 0, 32'h0000_0102, 32'h0,        32'h0000_7F00, 0, 0, 0, 4'b0010, 32'h0,        32'h0000_007F};

        rst_n = 1'b0;
        clear_inputs();
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'h0;
        last_rd = RST_RD;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) run_vec(vt[k]);

        // Reset asserted in the third REQ cycle of a slow load; the late ack must be ignored.
        @(posedge clk); #1;
        memRead_i = 1'b1; store_type_i = 2'b00; dataAddr_i = 32'h0000_0010;
        @(posedge clk); #1;
        chk("rst_seq_req", {31'h0, mem_req_o}, 32'h1);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk_reset_vals("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hCAFE_BABE;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        chk("late_ack_req", {31'h0, mem_req_o}, 32'h0);
        chk("late_ack_stall", {31'h0, stall_o}, 32'h0);
        chk("late_ack_rdata", rdata_o, RST_RD);
        @(posedge clk); #1;
        chk("late_ack_rdata2", rdata_o, RST_RD);
        last_rd = RST_RD;

        run_vec(vt[0]);

`ifdef DMEM_TIMEOUT_EN
        @(posedge clk); #1;
        memRead_i = 1'b1; store_type_i = 2'b00; dataAddr_i = 32'h0000_0020;
        exp_q.push_back(RST_RD);
        for (int i = 0; i < TO; i++) begin
            @(posedge clk); #1;
            chk("to_req", {31'h0, mem_req_o}, 32'h1);
            chk("to_berr_low", {31'h0, bus_err_o}, 32'h0);
        end
        @(posedge clk); #1;
        clear_inputs();
        #1;
        chk("to_berr", {31'h0, bus_err_o}, 32'h1);
        chk("to_stall", {31'h0, stall_o}, 32'h0);
        chk("to_req_drop", {31'h0, mem_req_o}, 32'h0);
        chk("to_rdata", rdata_o, RST_RD);
        @(posedge clk); #1;
        chk("to_berr_pulse", {31'h0, bus_err_o}, 32'h0);
        last_rd = RST_RD;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
